display_clock_gen: RTL and testbench
====================================

# display_clock_gen

Multi-channel, runtime-programmable successor to the single fixed-rate display divider. It generates CHANNELS independent 50%-duty square waves and one-cycle rising-edge tick strobes from CLOCK_50MHZ. Each channel's half-period is reloadable through a valid/ready port, and a new value takes effect only at a period boundary, so outputs never glitch. It feeds display multiplexing, blink and scan logic that each need a different rate.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- CNT_W, 32, counter and half-period width in bits
- DEFAULT_HALF, 32'd25_000_000, reset half-period in clocks for every channel (1 Hz at 50 MHz)
- CLOCK_50MHZ  in  1  system clock; all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- ENABLE  in  CHANNELS  per-channel run enable
- LOAD_VALID  in  1  half-period load request
- LOAD_CH  in  max(1,$clog2(CHANNELS))  target channel
- LOAD_HALF  in  CNT_W  new half-period in clocks
- LOAD_READY  out  1  load can be accepted
- SYNC  in  1  phase-restart strobe (see Configuration)
- WAVE  out  CHANNELS  square-wave outputs
- TICK  out  CHANNELS  one-cycle pulse on each WAVE rising edge
- PENDING  out  CHANNELS  channel holds an accepted but unapplied half-period

## Operation
- Per channel state: cnt, half (active), pend_half, pend flag, wave.
- Reset values: cnt=0, half=DEFAULT_HALF, pend=0, wave=0, TICK=0, PENDING=0, LOAD_READY reflects pend[LOAD_CH]; applies asynchronously on RESET_N low, including mid-period or mid-load.
- Running (ENABLE[i]=1): if cnt==half-1, then cnt<=0 and wave<=~wave; otherwise cnt<=cnt+1.
- Terminal edge with pend=1: half<=pend_half and pend<=0 in the same edge. The next count uses the new value.
- TICK[i]=1 for exactly the cycle after wave goes 0->1 (registered, aligned with WAVE high).
- Disabled (ENABLE[i]=0): cnt<=0, wave<=0, TICK<=0. A pending load applies on the next edge.
- LOAD_READY = ~pend[LOAD_CH]. A load is accepted when LOAD_VALID&&LOAD_READY: pend_half<=(LOAD_HALF==0 ? 1 : LOAD_HALF), pend<=1.
- LOAD_CH >= CHANNELS: LOAD_READY=1, the transfer is accepted and discarded.
- Accept and terminal on the same edge: the old pend (0) governs that terminal, so the new value applies at the following terminal.
- Counter arithmetic is unsigned CNT_W. Half-period range is 1..2^CNT_W-1. half=1 toggles WAVE every clock.

## Timing
- First WAVE rise occurs half edges after the first edge with ENABLE[i]=1. Period = 2*half clocks.
- LOAD_READY is combinational from LOAD_CH and registered pend. No combinational path exists from LOAD_VALID to LOAD_READY.
- Load-to-effect latency: at most one full half-period plus one clock.
- PENDING is registered and rises on the edge after acceptance.

## Configuration
- DISPLAY_CLOCK_GEN_SYNC_EN defined: SYNC=1 sampled on an edge forces every enabled channel to cnt<=0 and wave<=0, and applies any pending half-period immediately. SYNC has priority over the terminal-count update. TICK is suppressed on that edge.
- Macro undefined: the SYNC port still exists but is ignored, and no sync logic is synthesised.

## Test plan
- Reset, then ENABLE=4'b0001 with DEFAULT_HALF overridden to 3 -> WAVE[0] rises at edge 3, falls at edge 6, period 6. TICK[0] is high one cycle every 6. Other channels stay 0.
- Load LOAD_CH=0, LOAD_HALF=5 mid-period -> PENDING[0]=1 and LOAD_READY=0 for ch0 until the next terminal. The half-periods after that terminal are 5 clocks, with no short or long pulse.
- Second load to ch0 while pending, then a load to ch1 -> ch0 is not accepted (READY=0). The ch1 load is accepted in the same cycle.
- LOAD_HALF=0 on ch2 -> behaves as half=1: WAVE[2] toggles every clock and TICK[2] pulses every 2 clocks.
- Deassert ENABLE[1] mid-period, reassert after 7 cycles -> WAVE[1]=0 while off. The first rise comes half edges after re-enable. Assert RESET_N=0 asynchronously mid-count -> all outputs are 0 immediately.
- With DISPLAY_CLOCK_GEN_SYNC_EN defined: channels at half=3 and half=4 get SYNC pulsed -> both restart with cnt=0 and wave=0, and rise together 3 and 4 edges later. Without the macro, SYNC has no effect.

Source files
------------

// File: rtl/display_clock_gen.sv
// display_clock_gen: CHANNELS independent, runtime-reloadable 50%-duty dividers with rising-edge ticks.
// Define DISPLAY_CLOCK_GEN_SYNC_EN to make SYNC restart every enabled channel's phase.
module display_clock_gen #(
   parameter int               CHANNELS     = 4,
   parameter int               CNT_W        = 32,
   parameter logic [CNT_W-1:0] DEFAULT_HALF = 32'd25_000_000,
   localparam int              CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                CLOCK_50MHZ,
   input  logic                RESET_N,
   input  logic [CHANNELS-1:0] ENABLE,
   input  logic                LOAD_VALID,
   input  logic [CH_W-1:0]     LOAD_CH,
   input  logic [CNT_W-1:0]    LOAD_HALF,
   output logic                LOAD_READY,
   input  logic                SYNC,
   output logic [CHANNELS-1:0] WAVE,
   output logic [CHANNELS-1:0] TICK,
   output logic [CHANNELS-1:0] PENDING
);

   logic [(2**CH_W)-1:0] pend_pad;
   logic [CNT_W-1:0]     load_val;
   logic                 sync_now;

`ifdef DISPLAY_CLOCK_GEN_SYNC_EN
   assign sync_now = SYNC;
`else
   logic sync_unused;
   assign sync_unused = SYNC;
   assign sync_now    = 1'b0;
`endif

   // Channel numbers past CHANNELS see a zero pending bit, so they are always ready and discarded.
   always_comb begin
      pend_pad                = '0;
      pend_pad[CHANNELS-1:0]  = PENDING;
   end

   assign LOAD_READY = ~pend_pad[LOAD_CH];
   assign load_val   = (LOAD_HALF == '0) ? CNT_W'(1) : LOAD_HALF;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] half;
      logic [CNT_W-1:0] pend_half;
      logic             pend;
      logic             wave;
      logic             tick;
      logic             accept;
      logic             terminal;
      logic             hold;

      assign accept   = LOAD_VALID && LOAD_READY && (LOAD_CH == CH_W'(i));
      assign terminal = (cnt == half - CNT_W'(1));
      assign hold     = !ENABLE[i] || sync_now;

      // A pending half-period is only swapped in while the counter restarts, so no pulse is ever cut short.
      always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
         if (!RESET_N) begin
            cnt       <= '0;
            half      <= DEFAULT_HALF;
            pend_half <= DEFAULT_HALF;
            pend      <= 1'b0;
            wave      <= 1'b0;
            tick      <= 1'b0;
         end else begin
            if (accept) begin
               pend_half <= load_val;
               pend      <= 1'b1;
            end
            if (hold) begin
               cnt  <= '0;
               wave <= 1'b0;
               tick <= 1'b0;
            end else if (terminal) begin
               cnt  <= '0;
               wave <= ~wave;
               tick <= ~wave;
            end else begin
               cnt  <= cnt + CNT_W'(1);
               tick <= 1'b0;
            end
            if (pend && (hold || terminal)) begin
               half <= pend_half;
               pend <= 1'b0;
            end
         end
      end

      assign WAVE[i]    = wave;
      assign TICK[i]    = tick;
      assign PENDING[i] = pend;
   end

endmodule

// File: tb/tb_display_clock_gen.sv
// tb_display_clock_gen: directed scenarios plus random traffic, checked against an absolute-time
// reference model that schedules each channel's next toggle edge.
module tb_display_clock_gen;

   localparam int CH    = 4;
   localparam int HALF0 = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] en = '0;
   logic          ld_valid = 1'b0;
   logic [1:0]    ld_ch = '0;
   logic [31:0]   ld_half = '0;
   logic          sync = 1'b0;
   logic          ld_ready;
   logic [CH-1:0] wave;
   logic [CH-1:0] tick;
   logic [CH-1:0] pending;

   int            vectors = 0;
   int            errors = 0;

   longint        edge_n = 0;
   longint        m_half [CH];
   longint        m_phalf [CH];
   longint        m_next [CH];
   logic [CH-1:0] m_wave = '0;
   logic [CH-1:0] m_tick = '0;
   logic [CH-1:0] m_pend = '0;
   logic          sync_on;
   logic [12:0]   got;
   logic [12:0]   exp_v;

   always #5 clk = ~clk;

   display_clock_gen #(
      .CHANNELS     (CH),
      .CNT_W        (32),
      .DEFAULT_HALF (32'd3)
   ) dut (
      .CLOCK_50MHZ (clk),
      .RESET_N     (rst_n),
      .ENABLE      (en),
      .LOAD_VALID  (ld_valid),
      .LOAD_CH     (ld_ch),
      .LOAD_HALF   (ld_half),
      .LOAD_READY  (ld_ready),
      .SYNC        (sync),
      .WAVE        (wave),
      .TICK        (tick),
      .PENDING     (pending)
   );

`ifdef DISPLAY_CLOCK_GEN_SYNC_EN
   assign sync_on = sync;
`else
   assign sync_on = 1'b0;
`endif

   assign got   = {wave, tick, pending, ld_ready};
   assign exp_v = {m_wave, m_tick, m_pend, ~m_pend[ld_ch]};

   // Reference model: each channel remembers the absolute edge number of its next toggle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            m_half[c]  = HALF0;
            m_phalf[c] = HALF0;
            m_next[c]  = edge_n + HALF0;
         end
         m_wave = '0;
         m_tick = '0;
         m_pend = '0;
      end else begin
         edge_n = edge_n + 1;
         for (int c = 0; c < CH; c++) begin
            logic acc;
            acc = ld_valid && (int'(ld_ch) == c) && !m_pend[c];
            if (!en[c] || sync_on) begin
               if (m_pend[c]) begin
                  m_half[c] = m_phalf[c];
                  m_pend[c] = 1'b0;
               end
               m_wave[c] = 1'b0;
               m_tick[c] = 1'b0;
               m_next[c] = edge_n + m_half[c];
            end else if (edge_n == m_next[c]) begin
               m_tick[c] = !m_wave[c];
               m_wave[c] = !m_wave[c];
               if (m_pend[c]) begin
                  m_half[c] = m_phalf[c];
                  m_pend[c] = 1'b0;
               end
               m_next[c] = edge_n + m_half[c];
            end else begin
               m_tick[c] = 1'b0;
            end
            if (acc) begin
               m_phalf[c] = (ld_half == 0) ? 64'd1 : longint'(ld_half);
               m_pend[c]  = 1'b1;
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      en    = '0;
      repeat (2) @(negedge clk);
      vectors++;
      if (got !== 13'h001) begin
         errors++;
         $display("FAIL reset_state got=%b expected=%b", got, 13'h001);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_default_rate();
      en = 4'b0001;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         vectors++;
         if (wave !== {3'b000, logic'((k / 3) % 2 == 1)} || tick !== {3'b000, logic'(k % 6 == 3)}) begin
            errors++;
            $display("FAIL default_rate edge=%0d wave=%b tick=%b expected wave=%b tick=%b",
                     k, wave, tick, {3'b000, logic'((k / 3) % 2 == 1)}, {3'b000, logic'(k % 6 == 3)});
         end
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL default_model edge=%0d got=%b expected=%b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_load_pending();
      ld_valid = 1'b1;
      ld_ch    = 2'd0;
      ld_half  = 32'd5;
      @(negedge clk);
      vectors++;
      if (pending[0] !== 1'b1 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_pending pending0=%b ready=%b expected 1 and 0", pending[0], ld_ready);
      end
      vectors++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL load_model got=%b expected=%b", got, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      ld_half = 32'd7;
      @(negedge clk);
      vectors++;
      if (ld_ready !== 1'b0 || pending !== 4'b0001) begin
         errors++;
         $display("FAIL b2b_blocked ready=%b pending=%b expected 0 and 0001", ld_ready, pending);
      end
      ld_ch   = 2'd1;
      ld_half = 32'd4;
      @(negedge clk);
      vectors++;
      if (pending !== 4'b0010) begin
         errors++;
         $display("FAIL b2b_ch1_accept pending=%b expected 0010", pending);
      end
      vectors++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL b2b_model got=%b expected=%b", got, exp_v);
      end
      ld_valid = 1'b0;
   endtask

   task automatic test_reload_rate();
      for (int k = 16; k <= 30; k++) begin
         @(negedge clk);
         vectors++;
         if (wave[0] !== logic'(((k - 15) / 5) % 2 == 0) || tick[0] !== logic'((k - 15) % 10 == 0)) begin
            errors++;
            $display("FAIL reload_rate edge=%0d wave0=%b tick0=%b expected %b %b", k, wave[0], tick[0],
                     logic'(((k - 15) / 5) % 2 == 0), logic'((k - 15) % 10 == 0));
         end
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL reload_model edge=%0d got=%b expected=%b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_zero_half();
      ld_valid = 1'b1;
      ld_ch    = 2'd2;
      ld_half  = 32'd0;
      @(negedge clk);
      ld_valid = 1'b0;
      @(negedge clk);
      en = 4'b0101;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         vectors++;
         if (wave[2] !== logic'(j % 2) || tick[2] !== logic'(j % 2)) begin
            errors++;
            $display("FAIL zero_half step=%0d wave2=%b tick2=%b expected %b", j, wave[2], tick[2], logic'(j % 2));
         end
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL zero_model step=%0d got=%b expected=%b", j, got, exp_v);
         end
      end
   endtask

   task automatic test_enable_gap();
      en[1] = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
         vectors++;
         if (wave[1] !== logic'(j >= 4)) begin
            errors++;
            $display("FAIL gap_start step=%0d wave1=%b expected %b", j, wave[1], logic'(j >= 4));
         end
      end
      en[1] = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         vectors++;
         if (wave[1] !== 1'b0 || tick[1] !== 1'b0) begin
            errors++;
            $display("FAIL gap_off step=%0d wave1=%b tick1=%b expected 0", j, wave[1], tick[1]);
         end
      end
      en[1] = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         vectors++;
         if (wave[1] !== logic'(j >= 4) || tick[1] !== logic'(j == 4)) begin
            errors++;
            $display("FAIL gap_resume step=%0d wave1=%b tick1=%b expected %b %b", j, wave[1], tick[1],
                     logic'(j >= 4), logic'(j == 4));
         end
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL gap_model step=%0d got=%b expected=%b", j, got, exp_v);
         end
      end
   endtask

   task automatic test_sync();
      en[0]    = 1'b0;
      ld_valid = 1'b1;
      ld_ch    = 2'd0;
      ld_half  = 32'd3;
      @(negedge clk);
      ld_valid = 1'b0;
      @(negedge clk);
      en = 4'b0011;
      repeat (5) @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
`ifdef DISPLAY_CLOCK_GEN_SYNC_EN
      vectors++;
      if (wave[1:0] !== 2'b00 || tick[1:0] !== 2'b00) begin
         errors++;
         $display("FAIL sync_restart wave=%b tick=%b expected 00", wave[1:0], tick[1:0]);
      end
`endif
      for (int j = 1; j <= 6; j++) begin
         @(negedge clk);
`ifdef DISPLAY_CLOCK_GEN_SYNC_EN
         vectors++;
         if (wave[0] !== logic'(j >= 3) || wave[1] !== logic'(j >= 4)) begin
            errors++;
            $display("FAIL sync_align step=%0d wave=%b expected %b%b", j, wave[1:0], logic'(j >= 4), logic'(j >= 3));
         end
`endif
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL sync_model step=%0d got=%b expected=%b", j, got, exp_v);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL random_model cycle=%0d got=%b expected=%b", n, got, exp_v);
         end
         if ($urandom_range(0, 9) == 0) en = 4'($urandom);
         ld_valid = ($urandom_range(0, 2) == 0);
         ld_ch    = 2'($urandom);
         ld_half  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 6));
         sync     = ($urandom_range(0, 15) == 0);
      end
      ld_valid = 1'b0;
      sync     = 1'b0;
   endtask

   task automatic test_async_reset();
      en = 4'b1111;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (got !== 13'h001) begin
         errors++;
         $display("FAIL async_reset got=%b expected=%b", got, 13'h001);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         vectors++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL post_reset_model step=%0d got=%b expected=%b", j, got, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_rate();
      test_load_pending();
      test_back_to_back();
      test_reload_rate();
      test_zero_half();
      test_enable_gap();
      test_sync();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
